// File: rtl/neuron_seq_ctrl_pkg.sv
// neuron_seq_ctrl_pkg: Q-format constants, saturation bounds and sequencer states
package neuron_seq_ctrl_pkg;
  localparam int Q_N        = 32;
  localparam int Q_INTBITS  = 12;
  localparam int Q_FRACBITS = 20;
  localparam logic [Q_N-1:0] Q_ONE   = Q_N'(1) << Q_FRACBITS;
  localparam logic [Q_N-1:0] SAT_MAX = {1'b0, {(Q_N-1){1'b1}}};
  localparam logic [Q_N-1:0] SAT_MIN = {1'b1, {(Q_N-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
endpackage

// File: rtl/fxp_mac.sv
// fxp_mac: registered signed Q-format multiply/shift/accumulate with saturate+ReLU result
module fxp_mac
  import neuron_seq_ctrl_pkg::*;
#(
  parameter int N        = Q_N,
  parameter int INTBITS  = Q_INTBITS,
  parameter int FRACBITS = Q_FRACBITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] w,
  input  logic [N-1:0] x,
  output logic [N-1:0] result
);
  localparam int QW = INTBITS + FRACBITS;
  localparam logic signed [2*N-1:0] MAX_W = (2*N)'({1'b0, {(QW-1){1'b1}}});
  localparam logic signed [2*N-1:0] MIN_W = -MAX_W - 1;
  logic signed [2*N-1:0] acc;
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] sat;
  assign prod = (2*N)'($signed(w)) * (2*N)'($signed(x));
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + (prod >>> FRACBITS);
  // Saturate first, then ReLU clamps everything non-positive to zero
  assign sat    = acc > MAX_W ? MAX_W : acc < MIN_W ? MIN_W : acc;
  assign result = sat <= 0 ? '0 : sat[N-1:0];
endmodule

// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: time-shares one MAC across NEURONS neurons, S pairs each, valid/ready result port
module neuron_seq_ctrl
  import neuron_seq_ctrl_pkg::*;
#(
  parameter int S        = 8,
  parameter int NEURONS  = 2,
  parameter int N        = Q_N,
  parameter int INTBITS  = Q_INTBITS,
  parameter int FRACBITS = Q_FRACBITS,
  localparam int WA = (S*NEURONS > 1) ? $clog2(S*NEURONS) : 1,
  localparam int XA = (S > 1) ? $clog2(S) : 1,
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [WA-1:0] w_addr,
  output logic [XA-1:0] x_addr,
  output logic          rd_en,
  input  logic [N-1:0]  w_data,
  input  logic [N-1:0]  x_data,
  output logic [N-1:0]  out_data,
  output logic [NW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready
);
  state_t state, next_state;
  logic [XA-1:0] k;
  logic [NW-1:0] neuron;
  logic          rd_q, last, hs, take, clr, k_end;
  logic [N-1:0]  mac_out;
  assign last  = neuron == NW'(NEURONS-1);
  assign k_end = k == XA'(S-1);
  assign hs    = state == OUT && out_ready;
  // A start coinciding with done is held off until the following cycle
  assign take  = state == IDLE && start && !done;
  assign clr   = take || (hs && !last);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = take ? RUN
               : (state == RUN && k_end) ? DRAIN
               : state == DRAIN ? OUT
               : hs ? (last ? IDLE : RUN)
               : state;
    busy      = state != IDLE;
    rd_en     = state == RUN;
    w_addr    = rd_en ? WA'(int'(neuron) * S + int'(k)) : '0;
    x_addr    = rd_en ? k : '0;
    out_valid = state == OUT;
    out_data  = out_valid ? mac_out : '0;
    out_idx   = out_valid ? neuron : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      k      <= '0;
      neuron <= '0;
      rd_q   <= 1'b0;
      done   <= 1'b0;
    end else begin
      rd_q   <= rd_en;
      done   <= hs && last;
      k      <= clr ? '0 : rd_en ? (k_end ? '0 : k + XA'(1)) : k;
      neuron <= take ? '0 : (hs && !last) ? neuron + NW'(1) : neuron;
    end
  // Read data lands one cycle after rd_en, so the MAC is enabled by the delayed strobe
  fxp_mac #(.N(N), .INTBITS(INTBITS), .FRACBITS(FRACBITS)) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .en     (rd_q),
    .w      (w_data),
    .x      (x_data),
    .result (mac_out)
  );
endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb_neuron_seq_ctrl: scoreboard bench, directed Q12.20 vectors with hand-computed results
module tb_neuron_seq_ctrl;
  localparam int S = 4, NEURONS = 2, N = 32;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic busy, done, rd_en, out_valid;
  logic [2:0] w_addr;
  logic [1:0] x_addr;
  logic [0:0] out_idx;
  logic [N-1:0] w_data = '0, x_data = '0, out_data;
  logic [N-1:0] w_mem [8];
  logic [N-1:0] x_mem [4];
  logic [N:0] exp_q [$];
  int vectors = 0, miscompares = 0, done_cnt = 0, results = 0;

  neuron_seq_ctrl #(.S(S), .NEURONS(NEURONS)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .w_addr(w_addr), .x_addr(x_addr), .rd_en(rd_en), .w_data(w_data), .x_data(x_data),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) begin
    w_data <= w_mem[w_addr];
    x_data <= x_mem[x_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake
  always @(negedge clk) begin
    logic [N:0] e;
    #1;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      results++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got idx %0d data %h, none expected", out_idx, out_data);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({out_idx, out_data}), 64'(e));
      end
    end
  end

  task automatic load(input logic [N-1:0] w0 [4], input logic [N-1:0] w1 [4], input logic [N-1:0] x [4]);
    for (int i = 0; i < 4; i++) begin
      w_mem[i] = w0[i];
      w_mem[i+4] = w1[i];
      x_mem[i] = x[i];
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int r0);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < 200) begin
      @(negedge clk); #2; i++;
    end
    check({name, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_count"}, 64'(results - r0), 64'd2);
    check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset(input string name);
    check(name, 64'({busy, done, rd_en, out_valid, w_addr, x_addr, out_idx, out_data}), 64'd0);
  endtask

  initial begin
    logic [N-1:0] w0 [4], w1 [4], x [4];
    int r0, d0, i;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    reset = 1'b0;

    // Basic: 4 x 1.0*1.0 and 4 x -1.0*1.0
    w0 = '{default: 32'h00100000}; w1 = '{default: 32'hFFF00000}; x = '{default: 32'h00100000};
    load(w0, w1, x);
    exp_q.push_back({1'b0, 32'h00400000});
    exp_q.push_back({1'b1, 32'h00000000});
    r0 = results;
    pulse_start();
    wait_done("basic", r0);
    start = 1'b1;
    @(negedge clk); #2;
    check("start_on_done_ignored", 64'(busy), 64'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_single", 64'(done_cnt), 64'd1);

    // Saturation: 4 x 2047.0*2.0 = 16376, and 4 x 0.5*2.0 = 4.0
    w0 = '{default: 32'h7FF00000}; w1 = '{default: 32'h00080000}; x = '{default: 32'h00200000};
    load(w0, w1, x);
    exp_q.push_back({1'b0, 32'h7FFFFFFF});
    exp_q.push_back({1'b1, 32'h00400000});
    r0 = results;
    pulse_start();
    wait_done("saturate", r0);

    // Mixed signs with backpressure: 3-2-1+1 = 1.0 and 3-2-2+1 = 0
    w0 = '{32'h00180000, 32'hFFF80000, 32'h00020000, 32'h00200000};
    w1 = '{32'h00180000, 32'hFFF80000, 32'h00040000, 32'h00200000};
    x  = '{32'h00200000, 32'h00400000, 32'hFF800000, 32'h00080000};
    load(w0, w1, x);
    exp_q.push_back({1'b0, 32'h00100000});
    exp_q.push_back({1'b1, 32'h00000000});
    r0 = results;
    out_ready = 1'b0;
    pulse_start();
    i = 0;
    while (!out_valid && i < 50) begin
      @(negedge clk); #2; i++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2;
      check("hold", 64'({out_valid, rd_en, out_idx, out_data}), 64'({1'b1, 1'b0, 1'b0, 32'h00100000}));
    end
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk); #2;
    check("release_run", 64'({rd_en, w_addr, out_valid}), 64'({1'b1, 3'd4, 1'b0}));
    wait_done("mixed", r0);

    // Floor truncation, wide accumulation, start during RUN
    w0 = '{32'hFFFFFFFF, 32'h00000003, 32'h00000003, 32'h00000003};
    w1 = '{default: 32'h7FFFFFFF}; x = '{default: 32'h00080000};
    load(w0, w1, x);
    exp_q.push_back({1'b0, 32'h00000002});
    exp_q.push_back({1'b1, 32'h7FFFFFFF});
    r0 = results;
    @(negedge clk) start = 1'b1;
    @(negedge clk); #2;
    check("run_k0", 64'({busy, rd_en, w_addr}), 64'({1'b1, 1'b1, 3'd0}));
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    check("no_restart", 64'({busy, rd_en, w_addr, x_addr}), 64'({1'b1, 1'b1, 3'd1, 2'd1}));
    wait_done("trunc", r0);

    // Reset at k=2 of neuron0, then a clean rerun
    w0 = '{default: 32'h00100000}; w1 = '{default: 32'hFFF00000}; x = '{default: 32'h00100000};
    load(w0, w1, x);
    d0 = done_cnt;
    r0 = results;
    pulse_start();
    i = 0;
    while (!(rd_en && x_addr == 2'd2) && i < 50) begin
      @(negedge clk); #2; i++;
    end
    reset = 1'b1;
    #1;
    check_reset("async_reset");
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_no_done", 64'({done_cnt - d0, results - r0}), 64'd0);
    exp_q.push_back({1'b0, 32'h00400000});
    exp_q.push_back({1'b1, 32'h00000000});
    pulse_start();
    wait_done("after_reset", r0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
